pwm_capture_7ch: RTL and testbench



---
 rtl/pwm_capture_7ch_if.sv | 25 ++
 rtl/pwm_capture_7ch.sv | 95 +++++++++
 tb/tb_pwm_capture_7ch.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_7ch_if.sv
// Bundle of the PWM capture inputs and its duty/strobe results.
// The master drives the PWM lines and readout select; the slave is the decoder.
interface pwm_capture_7ch_if #(
    parameter int MAX_COUNT = 100
);
    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [6:0]    pwm_in;
    logic          freeze;
    logic [2:0]    ch_sel;
    logic [CW-1:0] duty_out;
    logic          valid;
    logic [6:0]    full;
    logic [6:0]    zero;

    modport master (
        output pwm_in, freeze, ch_sel,
        input  duty_out, valid, full, zero
    );

    modport slave (
        input  pwm_in, freeze, ch_sel,
        output duty_out, valid, full, zero
    );
endinterface

// File: rtl/pwm_capture_7ch.sv
// Seven-channel PWM capture: counts synchronized high clocks over a fixed
// MAX_COUNT-clock window and latches per-channel duty, full and zero flags.
module pwm_capture_7ch #(
    parameter int MAX_COUNT   = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    pwm_capture_7ch_if.slave        bus
);
    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [SYNC_STAGES-1:0][6:0] sync_q, sync_d;
    logic [CW-1:0]               win_cnt_q, win_cnt_d;
    logic [6:0][CW-1:0]          acc_q, acc_d;
    logic [6:0][CW-1:0]          duty_q, duty_d;
    logic [6:0][CW-1:0]          total;
    logic [6:0]                  full_q, full_d;
    logic [6:0]                  zero_q, zero_d;
    logic                        valid_q, valid_d;
    logic [CW-1:0]               duty_out_q, duty_out_d;
    logic [6:0]                  pwm_s;
    logic                        last_cycle;

    assign pwm_s      = sync_q[SYNC_STAGES-1];
    assign last_cycle = (win_cnt_q == CW'(MAX_COUNT - 1));

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        sync_d     = sync_q;
        win_cnt_d  = last_cycle ? '0 : win_cnt_q + CW'(1);
        acc_d      = acc_q;
        duty_d     = duty_q;
        full_d     = full_q;
        zero_d     = zero_q;
        valid_d    = 1'b0;
        total      = '0;
        duty_out_d = '0;

        sync_d[0] = bus.pwm_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        // The window total includes this cycle's sample, so a constant-high input reaches MAX_COUNT.
        for (int i = 0; i < 7; i++) begin
            total[i] = acc_q[i] + CW'(pwm_s[i]);
            acc_d[i] = last_cycle ? '0 : total[i];
        end

        if (last_cycle && !bus.freeze) begin
            valid_d = 1'b1;
            for (int i = 0; i < 7; i++) begin
                duty_d[i] = total[i];
                full_d[i] = (total[i] == CW'(MAX_COUNT));
                zero_d[i] = (total[i] == '0);
            end
        end

        // Readout samples the pre-latch duty, so a same-edge latch shows up one cycle later.
        for (int i = 0; i < 7; i++) begin
            if (bus.ch_sel == 3'(i)) begin
                duty_out_d = duty_q[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            win_cnt_q  <= '0;
            acc_q      <= '0;
            duty_q     <= '0;
            full_q     <= '0;
            zero_q     <= 7'h7F;
            valid_q    <= 1'b0;
            duty_out_q <= '0;
        end else begin
            sync_q     <= sync_d;
            win_cnt_q  <= win_cnt_d;
            acc_q      <= acc_d;
            duty_q     <= duty_d;
            full_q     <= full_d;
            zero_q     <= zero_d;
            valid_q    <= valid_d;
            duty_out_q <= duty_out_d;
        end
    end

    assign bus.duty_out = duty_out_q;
    assign bus.valid    = valid_q;
    assign bus.full     = full_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_pwm_capture_7ch.sv
// Directed bench for pwm_capture_7ch: a per-channel PWM generator feeds the
// inputs and each scenario task checks window timing, duties, flags and readout.
module tb_pwm_capture_7ch;
    localparam int MAX_COUNT = 100;
    localparam int CW        = 7;

    logic clk = 1'b0;
    logic rst;

    pwm_capture_7ch_if #(.MAX_COUNT(MAX_COUNT)) bus ();

    pwm_capture_7ch #(
        .MAX_COUNT  (MAX_COUNT),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    int per[7];
    int hi[7];
    int gen_cnt = 0;

    // Channel i is high for hi[i] clocks of every per[i] clocks.
    initial begin
        for (int i = 0; i < 7; i++) begin
            per[i] = 1;
            hi[i]  = 0;
        end
        bus.pwm_in = '0;
        forever begin
            @(negedge clk);
            gen_cnt++;
            for (int i = 0; i < 7; i++) begin
                bus.pwm_in[i] = ((gen_cnt % per[i]) < hi[i]);
            end
        end
    end

    task automatic set_all(input int p, input int h);
        for (int i = 0; i < 7; i++) begin
            per[i] = p;
            hi[i]  = h;
        end
    endtask

    // Returns the number of negedges until valid is seen, or 0 if the budget expires.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic read_duty(input int ch, output logic [CW-1:0] v);
        @(negedge clk);
        bus.ch_sel = 3'(ch);
        @(negedge clk);
        v = bus.duty_out;
    endtask

    // Release lands on a negedge; that cycle is the first with win_cnt = 0.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b expected 0", bus.valid);
        end
        tests_run++;
        if (bus.duty_out !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_duty_out: got %0d expected 0", bus.duty_out);
        end
        tests_run++;
        if (bus.full !== 7'h00) begin
            tests_failed++;
            $display("FAIL reset_full: got %b expected 0000000", bus.full);
        end
        tests_run++;
        if (bus.zero !== 7'h7F) begin
            tests_failed++;
            $display("FAIL reset_zero: got %b expected 1111111", bus.zero);
        end
    endtask

    task automatic test_const_high();
        int n;
        logic [CW-1:0] v;
        set_all(1, 0);
        hi[0] = 1;
        apply_reset();
        wait_valid(150, n);
        tests_run++;
        if (n !== 100) begin
            tests_failed++;
            $display("FAIL first_valid_cycle: got %0d expected 100", n);
        end
        tests_run++;
        if (bus.full !== 7'b0000000 || bus.zero !== 7'b1111110) begin
            tests_failed++;
            $display("FAIL win1_flags: got full=%b zero=%b expected full=0000000 zero=1111110", bus.full, bus.zero);
        end
        read_duty(0, v);
        tests_run++;
        if (v !== 7'd98) begin
            tests_failed++;
            $display("FAIL win1_duty0: got %0d expected 98", v);
        end
        wait_valid(150, n);
        tests_run++;
        if (n !== 98) begin
            tests_failed++;
            $display("FAIL win2_period: got %0d expected 98", n);
        end
        tests_run++;
        if (bus.full !== 7'b0000001 || bus.zero !== 7'b1111110) begin
            tests_failed++;
            $display("FAIL win2_flags: got full=%b zero=%b expected full=0000001 zero=1111110", bus.full, bus.zero);
        end
        read_duty(0, v);
        tests_run++;
        if (v !== 7'd100) begin
            tests_failed++;
            $display("FAIL win2_duty0: got %0d expected 100", v);
        end
    endtask

    task automatic test_ch3();
        int n;
        logic [CW-1:0] v;
        set_all(1, 0);
        per[3] = 100;
        hi[3]  = 37;
        for (int w = 0; w < 3; w++) begin
            wait_valid(150, n);
            tests_run++;
            if (n == 0) begin
                tests_failed++;
                $display("FAIL ch3_window_timeout: got no valid expected valid within 150");
            end
            if (w > 0) begin
                tests_run++;
                if (bus.zero !== 7'b1110111 || bus.full !== 7'b0000000) begin
                    tests_failed++;
                    $display("FAIL ch3_flags: got zero=%b full=%b expected zero=1110111 full=0000000", bus.zero, bus.full);
                end
                read_duty(3, v);
                tests_run++;
                if (v !== 7'd37) begin
                    tests_failed++;
                    $display("FAIL ch3_duty: got %0d expected 37", v);
                end
            end
        end
        read_duty(0, v);
        tests_run++;
        if (v !== 7'd0) begin
            tests_failed++;
            $display("FAIL ch3_idle_ch0: got %0d expected 0", v);
        end
    endtask

    task automatic test_all_50();
        int n;
        logic [CW-1:0] v;
        set_all(10, 5);
        repeat (2) begin
            wait_valid(150, n);
            tests_run++;
            if (n == 0) begin
                tests_failed++;
                $display("FAIL half_window_timeout: got no valid expected valid within 150");
            end
        end
        tests_run++;
        if (bus.zero !== 7'h00 || bus.full !== 7'h00) begin
            tests_failed++;
            $display("FAIL half_flags: got zero=%b full=%b expected 0000000/0000000", bus.zero, bus.full);
        end
        for (int ch = 0; ch < 7; ch++) begin
            read_duty(ch, v);
            tests_run++;
            if (v !== 7'd50) begin
                tests_failed++;
                $display("FAIL half_duty ch%0d: got %0d expected 50", ch, v);
            end
        end
    endtask

    task automatic test_sel_range();
        logic [CW-1:0] v;
        read_duty(7, v);
        tests_run++;
        if (v !== 7'd0) begin
            tests_failed++;
            $display("FAIL sel7_duty_out: got %0d expected 0", v);
        end
        read_duty(2, v);
        tests_run++;
        if (v !== 7'd50) begin
            tests_failed++;
            $display("FAIL sel7_to_2: got %0d expected 50", v);
        end
    endtask

    task automatic test_freeze();
        int n;
        int seen;
        logic [CW-1:0] v;
        set_all(1, 0);
        per[1] = 100;
        hi[1]  = 20;
        repeat (2) wait_valid(150, n);
        read_duty(1, v);
        tests_run++;
        if (v !== 7'd20) begin
            tests_failed++;
            $display("FAIL freeze_pre_duty1: got %0d expected 20", v);
        end
        wait_valid(150, n);
        hi[1]      = 80;
        bus.freeze = 1'b1;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) seen++;
        end
        bus.freeze = 1'b0;
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL freeze_valid_pulses: got %0d expected 0", seen);
        end
        tests_run++;
        if (bus.duty_out !== 7'd20) begin
            tests_failed++;
            $display("FAIL freeze_held_duty1: got %0d expected 20", bus.duty_out);
        end
        wait_valid(150, n);
        tests_run++;
        if (n !== 100) begin
            tests_failed++;
            $display("FAIL unfreeze_valid_cycle: got %0d expected 100", n);
        end
        tests_run++;
        if (bus.duty_out !== 7'd20) begin
            tests_failed++;
            $display("FAIL same_edge_readout: got %0d expected 20", bus.duty_out);
        end
        @(negedge clk);
        tests_run++;
        if (bus.duty_out !== 7'd80) begin
            tests_failed++;
            $display("FAIL unfreeze_duty1: got %0d expected 80", bus.duty_out);
        end
        tests_run++;
        if (bus.full !== 7'h00 || bus.zero !== 7'b1111101) begin
            tests_failed++;
            $display("FAIL unfreeze_flags: got full=%b zero=%b expected 0000000/1111101", bus.full, bus.zero);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [CW-1:0] v;
        set_all(1, 1);
        bus.ch_sel = 3'd4;
        wait_valid(150, n);
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.valid !== 1'b0 || bus.duty_out !== 7'd0 || bus.full !== 7'h00 || bus.zero !== 7'h7F) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got valid=%b duty_out=%0d full=%b zero=%b expected 0/0/0000000/1111111",
                     bus.valid, bus.duty_out, bus.full, bus.zero);
        end
        rst = 1'b0;
        wait_valid(150, n);
        tests_run++;
        if (n !== 100) begin
            tests_failed++;
            $display("FAIL mid_reset_first_valid: got %0d expected 100", n);
        end
        tests_run++;
        if (bus.full !== 7'h00 || bus.zero !== 7'h00) begin
            tests_failed++;
            $display("FAIL mid_reset_flags: got full=%b zero=%b expected 0000000/0000000", bus.full, bus.zero);
        end
        for (int ch = 0; ch < 7; ch++) begin
            read_duty(ch, v);
            tests_run++;
            if (v !== 7'd98) begin
                tests_failed++;
                $display("FAIL mid_reset_duty ch%0d: got %0d expected 98", ch, v);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.freeze = 1'b0;
        bus.ch_sel = 3'd0;
        test_reset();
        test_const_high();
        test_ch3();
        test_all_50();
        test_sel_range();
        test_freeze();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
